// File: rtl/regfile_32x32.sv
// 32 x DATA_W register file: one one-hot-selected write port, two combinational
// read ports with write-first bypass, a debug read port, select checking and a write counter.
module regfile_32x32 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [31:0]       wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              onehot_err,
    output logic [CNT_W-1:0]  wr_count
);

    logic [DATA_W-1:0] regs [1:31];
    logic [DATA_W-1:0] view [0:31];
    logic              sel_legal;
    logic              commit;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign sel_legal = (wsel != '0) && ((wsel & (wsel - 32'd1)) == '0);
    assign commit    = !rst && wen && sel_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            onehot_err <= 1'b0;
            wr_count   <= '0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (commit && wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
            if (wen && !sel_legal) begin
                onehot_err <= 1'b1;
            end
            if (commit && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    // Full 32-entry view with a constant-zero slot 0 so reads index in range.
    always_comb begin
        view[0] = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            view[i] = regs[i];
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && (raddr1 != 5'd0)) begin
            rdata1 = (commit && wsel[raddr1]) ? wdata : view[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && (raddr2 != 5'd0)) begin
            rdata2 = (commit && wsel[raddr2]) ? wdata : view[raddr2];
        end
    end

    always_comb begin
        dbg_data = '0;
        if (!rst) begin
            dbg_data = view[dbg_addr];
        end
    end

endmodule

// File: doc/regfile_32x32.md
# regfile_32x32

Register file with 32 registers × 32 bits, one write port and two asynchronous read ports. It sits directly downstream of the 5-to-32 write-address decoder and takes that decoder's one-hot output as its write-select. The write-address path (decoder) and the storage/read path (this block) stay separate, so the datapath reuses the decoder unchanged. The block also checks that the decoded select is legal and counts committed writes.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- wen  input  1  write enable from control unit.
- wsel  input  32  one-hot write select from the 5-to-32 decoder; bit i selects register i.
- wdata  input  DATA_W  write data.
- raddr1  input  5  read address, port 1.
- raddr2  input  5  read address, port 2.
- rdata1  output  DATA_W  read data, port 1.
- rdata2  output  DATA_W  read data, port 2.
- dbg_addr  input  5  debug read address.
- dbg_data  output  DATA_W  debug read data (storage contents only, no bypass).
- onehot_err  output  1  sticky flag: an illegal wsel was seen while wen=1.
- wr_count  output  CNT_W  saturating count of committed writes.

## Operation
- Storage: regs[1..31], each DATA_W bits. Register 0 is hardwired to 0; there is no storage for it and writes to it are discarded.
- Select legality: with wen=1, wsel is legal only if exactly one bit is set.
  - wsel=0 with wen=1: illegal.
  - Two or more bits set with wen=1: illegal.
  - With wen=0, wsel is don't-care and is never checked.
- Commit: at a rising edge with rst=0, wen=1 and a legal wsel selecting bit i:
  - i≠0: regs[i] ← wdata, and wr_count increments.
  - i=0: legal, but nothing is stored; wr_count still increments (counts accepted write cycles).
- Illegal select: at a rising edge with rst=0, wen=1 and an illegal wsel:
  - no register changes;
  - onehot_err ← 1;
  - wr_count does not change.
- onehot_err is sticky and clears only on rst.
- wr_count saturates at 2^CNT_W−1 and does not wrap.
- Read ports are combinational. For each port p:
  - raddr_p=0 → rdata_p = 0.
  - Otherwise, if this cycle's write is legal and targets raddr_p → rdata_p = wdata (write-first bypass).
  - Otherwise → rdata_p = regs[raddr_p].
- Both ports may read the same address; each follows the rules above independently.
- Debug port: dbg_data = regs[dbg_addr], or 0 when dbg_addr=0. It never bypasses, so it shows committed state only.

## Timing
- Reset values: regs[1..31]=0, onehot_err=0, wr_count=0. With rst asserted, rdata1, rdata2 and dbg_data read 0 for every address; the bypass is suppressed while rst=1.
- rst has priority: if rst=1 and a write is presented on the same edge, the write is dropped and the counter and flag are cleared.
- Rising edge after rst deasserts: normal commits resume.
- Write latency: a value is committed at the edge ending the cycle in which it is presented. Read ports show it in that same cycle via the bypass. dbg_data shows it from the next cycle.
- Back-to-back writes to the same register: the last one wins; each legal write counts once.
- Read latency: zero cycles, combinational from raddr, wsel, wen and wdata.
- onehot_err and wr_count update at the edge and are registered outputs.

## Test plan
- Reset then readback: assert rst for 1 cycle, sweep raddr1, raddr2 and dbg_addr over 0..31 → all read 0; onehot_err=0; wr_count=0.
- Write/read: wen=1, wsel=32'h0000_0020, wdata=32'hDEAD_BEEF.
  - In the same cycle with raddr1=5 → rdata1=DEADBEEF (bypass) while dbg_data at address 5 still reads 0.
  - Next cycle → dbg_data at address 5 = DEADBEEF; wr_count=1.
- Register 0: wen=1, wsel=32'h1, wdata=32'hFFFF_FFFF → rdata1 at address 0 reads 0 in that cycle and the next; wr_count increments by 1.
- Illegal select:
  - wen=1, wsel=32'h0000_0006, wdata=32'h1234 → regs 1 and 2 unchanged, onehot_err=1 from the next cycle, wr_count unchanged.
  - Later legal writes still commit, and onehot_err stays 1 until rst.
- wen=0 with garbage wsel=32'hFFFF_FFFF → no change and onehot_err stays 0.
- Reset mid-write: rst=1 on the same edge as a legal write of 32'hA5A5 to register 7 → next cycle reg 7 reads 0 and wr_count=0.
- Saturation (CNT_W=4): perform 20 legal writes → wr_count stops at 15.
